ring_osc_freq_meter: RTL and testbench

Controller and edge counter for the inverter-chain ring oscillator.
- Drives the ring's enable, then gates a measurement window in the system clock domain.
- Samples the ring's asynchronous clk_out through a synchronizer and counts its rising edges over a fixed number of system clock cycles.
- The result is the ring frequency expressed as edges per window; used to characterise inverter delay and synchronizer behaviour.

---
 rtl/ring_osc_freq_meter.sv | 166 ++++++++++++++++
 tb/tb_ring_osc_freq_meter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
// ring_osc_freq_meter: enables the ring oscillator, lets it settle for
// WARMUP_CYCLES, then counts synchronized rising edges of ring_clk over
// WINDOW_CYCLES system clocks. The result is edges per window.
//
// Build option: define RING_MEAS_SYNC3_EN for a 3-flop synchronizer.
// The extra stage's latency is absorbed by the warmup period, so the
// window, the busy duration and the count_valid timing are unchanged.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | ring off, last result held, waiting for start
// ST_WARMUP  | ring on, synchronizer filling, count frozen
// ST_MEASURE | ring on, counting synchronized rising edges
module ring_osc_freq_meter #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int WARMUP_CYCLES = 16,
    parameter int CNT_W         = 16,
    parameter int TIMER_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ring_clk,
    output logic             ring_en,
    output logic             busy,
    output logic             count_valid,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

`ifdef RING_MEAS_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam logic [TIMER_W-1:0] WARMUP_LOAD = TIMER_W'(WARMUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_MEASURE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   ring_rise;

    state_t             state_q,  state_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               sat_q,    sat_d;
    logic               valid_q,  valid_d;
    logic               active_q, active_d;

    // Synchronize the asynchronous ring clock and keep one sample of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ring_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ring_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Controller state, timer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
            active_q <= active_d;
        end
    end

    // Next-state logic; abort outranks window completion.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        sat_d    = sat_q;
        valid_d  = valid_q;
        active_d = active_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_WARMUP;
                    active_d = 1'b1;
                    valid_d  = 1'b0;
                    count_d  = '0;
                    sat_d    = 1'b0;
                    timer_d  = WARMUP_LOAD;
                end
            end

            ST_WARMUP: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    valid_d  = 1'b0;
                    count_d  = '0;
                    sat_d    = 1'b0;
                end else if (timer_q == '0) begin
                    state_d = ST_MEASURE;
                    timer_d = WINDOW_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            ST_MEASURE: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    valid_d  = 1'b0;
                    count_d  = '0;
                    sat_d    = 1'b0;
                end else begin
                    // The edge seen in the final window cycle still counts.
                    if (ring_rise) begin
                        if (count_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                    if (timer_q == '0) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        valid_d  = 1'b1;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    assign ring_en     = active_q;
    assign busy        = active_q;
    assign count_valid = valid_q;
    assign count       = count_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter. Time unit of every delay here is 100 ps:
// clk period 100 units (10 ns); ring toggles sit on a 0.3 ns offset so they
// never coincide with a clk edge.
module tb_ring_osc_freq_meter;

    localparam int WIN = 100;
    localparam int WU  = 4;
    localparam int BUSY_LEN = WIN + WU;
`ifdef RING_MEAS_SYNC3_EN
    localparam int SYNC_L = 3;
`else
    localparam int SYNC_L = 2;
`endif
    localparam int SMP_N = 16384;

    logic        clk, rst_n;
    logic        start, abort, ring_clk;
    logic        ring_en, busy, count_valid, sat;
    logic [15:0] count;

    logic        start_s, abort_s, ring_clk_s;
    logic        ring_en_s, busy_s, count_valid_s, sat_s;
    logic [2:0]  count_s;

    int checks = 0;
    int errors = 0;
    int ring_half = 50;
    int ring_half_s = 20;
    int edge_no = 0;
    int last_exp = 0;
    logic smp [0:SMP_N-1];

    typedef struct {
        int half;
        int lo;
        int hi;
    } vec_t;
    vec_t vecs [4];

    ring_osc_freq_meter #(.WINDOW_CYCLES(WIN), .WARMUP_CYCLES(WU), .CNT_W(16), .TIMER_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ring_clk(ring_clk),
        .ring_en(ring_en), .busy(busy), .count_valid(count_valid), .count(count), .sat(sat)
    );

    ring_osc_freq_meter #(.WINDOW_CYCLES(WIN), .WARMUP_CYCLES(WU), .CNT_W(3), .TIMER_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .ring_clk(ring_clk_s),
        .ring_en(ring_en_s), .busy(busy_s), .count_valid(count_valid_s), .count(count_s), .sat(sat_s)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Ring models: free-running toggler that only oscillates while enabled.
    initial begin
        ring_clk = 1'b0;
        #3;
        forever begin
            #(ring_half * 10);
            ring_clk = ring_en ? ~ring_clk : 1'b0;
        end
    end

    initial begin
        ring_clk_s = 1'b0;
        #3;
        forever begin
            #(ring_half_s * 10);
            ring_clk_s = ring_en_s ? ~ring_clk_s : 1'b0;
        end
    end

    // Record the ring level seen at every clk edge for the reference model.
    always @(posedge clk) begin
        smp[edge_no % SMP_N] <= ring_clk;
        edge_no <= edge_no + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Rising edges of the sampled ring waveform that land in the window:
    // a transition between samples j-1 and j is seen SYNC_L-1 edges later.
    function automatic int model_edges(input int a);
        int n = 0;
        for (int k = WU; k < WU + WIN; k++) begin
            if (smp[(a + k - SYNC_L + 1) % SMP_N] && !smp[(a + k - SYNC_L) % SMP_N])
                n++;
        end
        return n;
    endfunction

    // Pulse start from IDLE; returns the acceptance edge index.
    task automatic pulse_start(output int a);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = edge_no - 1;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic run_measure(input string tag, input int half, input int lo, input int hi,
                               input int repulse_at);
        int a, nb, ne, guard, exp_n;
        logic vbad;
        ring_half = half;
        pulse_start(a);
        nb = 0; ne = 0; guard = 0; vbad = 1'b0;
        while (busy && guard < 400) begin
            nb++;
            if (ring_en) ne++;
            if (count_valid) vbad = 1'b1;
            start = (nb == repulse_at);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        exp_n = model_edges(a);
        last_exp = exp_n;
        chk({tag, "_busy_len"}, nb, BUSY_LEN);
        chk({tag, "_ring_en_len"}, ne, BUSY_LEN);
        chk({tag, "_ring_en_off"}, int'(ring_en), 0);
        chk({tag, "_valid_low_busy"}, int'(vbad), 0);
        chk({tag, "_valid"}, int'(count_valid), 1);
        chk({tag, "_count_model"}, int'(count), exp_n);
        chk_range({tag, "_count_range"}, int'(count), lo, hi);
        chk({tag, "_sat"}, int'(sat), 0);
    endtask

    initial begin
        int a, nb, guard, h, nom;

        vecs[0] = '{50, 9, 11};
        vecs[1] = '{25, 19, 21};
        vecs[2] = '{100, 4, 6};
        vecs[3] = '{13, 37, 40};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start_s = 1'b0; abort_s = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ring_en", int'(ring_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(count_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_sat", int'(sat), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table of ring periods with the nominal edges-per-microsecond window.
        for (int i = 0; i < 4; i++)
            run_measure($sformatf("vec%0d", i), vecs[i].half, vecs[i].lo, vecs[i].hi, -1);

        // Randomized ring periods, all slower than clk/2.
        for (int i = 0; i < 6; i++) begin
            h = int'($urandom_range(11, 120));
            nom = 1000 / (2 * h);
            run_measure($sformatf("rnd%0d", i), h, nom - 1, nom + 1, -1);
        end

        // abort in IDLE leaves the result alone
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_valid", int'(count_valid), 1);
        chk("idle_abort_count", int'(count), last_exp);

        // start re-pulsed during MEASURE is ignored
        run_measure("repulse", 50, 9, 11, WU + 60);

        // abort at MEASURE cycle 50, then a clean run
        ring_half = 50;
        pulse_start(a);
        repeat (WU + 50) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ring_en", int'(ring_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(count_valid), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_sat", int'(sat), 0);
        run_measure("post_abort", 50, 9, 11, -1);

        // abort in the same cycle the window timer expires
        pulse_start(a);
        repeat (BUSY_LEN - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_last_busy", int'(busy), 0);
        chk("abort_last_valid", int'(count_valid), 0);
        chk("abort_last_count", int'(count), 0);

        // abort and start together in IDLE: start wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle_busy", int'(busy), 1);
        wait_idle("abort_start_idle_done");

        // start held high: back-to-back runs with a single valid cycle
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        nb = 0; guard = 0;
        while (busy && guard < 400) begin
            nb++;
            @(negedge clk);
            guard++;
        end
        chk("held_busy_len", nb, BUSY_LEN);
        chk("held_gap_valid", int'(count_valid), 1);
        @(negedge clk);
        chk("held_rerun_busy", int'(busy), 1);
        chk("held_rerun_valid", int'(count_valid), 0);
        start = 1'b0;
        wait_idle("held_done");

        // asynchronous reset mid-MEASURE
        pulse_start(a);
        repeat (WU + 50) @(negedge clk);
        #20;
        rst_n = 1'b0;
        #10;
        chk("amid_rst_ring_en", int'(ring_en), 0);
        chk("amid_rst_busy", int'(busy), 0);
        chk("amid_rst_valid", int'(count_valid), 0);
        chk("amid_rst_count", int'(count), 0);
        chk("amid_rst_sat", int'(sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        run_measure("post_rst", 50, 9, 11, -1);

        // 3-bit counter saturates on a 40 ns ring (about 25 edges)
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        nb = 0; guard = 0;
        while (busy_s && guard < 400) begin
            nb++;
            @(negedge clk);
            guard++;
        end
        chk("sat_busy_len", nb, BUSY_LEN);
        chk("sat_count", int'(count_s), 7);
        chk("sat_flag", int'(sat_s), 1);
        chk("sat_valid", int'(count_valid_s), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
